// File: rtl/morse_pkg.sv
// Shared types and timing ratios for the Morse key front end.
//   key_state_t      : sequencer FSM states
//   DASH_SPLIT_UNITS : a press of this many units or more is a dash
//   CHAR_GAP_UNITS   : gap length (units) that closes a character
//   WORD_GAP_UNITS   : gap length (units) that closes a word
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    GAP,
    CHAR_DONE,
    STUCK
  } key_state_t;

  localparam int unsigned DASH_SPLIT_UNITS = 2;
  localparam int unsigned CHAR_GAP_UNITS   = 2;
  localparam int unsigned WORD_GAP_UNITS   = 5;

endpackage

// File: rtl/morse_key_debounce.sv
// Key line conditioner: 2-flop synchroniser followed by a debounce counter.
// A level change is accepted after DEB_CYCLES consecutive equal synchronised
// samples, so every key_db edge lags key_in by 2+DEB_CYCLES clocks and
// press/gap durations are preserved.
//   clk    : system clock
//   rst    : asynchronous active-low reset (key_db forced to 0)
//   key_in : raw asynchronous key, 1 = pressed
//   key_db : debounced key level
module morse_key_debounce #(
  parameter int unsigned DEB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          key_db_q, key_db_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], key_in};
    key_db_d = key_db_q;
    cnt_d    = '0;
    // cnt_q holds how many earlier consecutive samples already disagreed
    if (sync_q[1] != key_db_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) begin
        key_db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      key_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_db = key_db_q;

endmodule

// File: rtl/morse_key_sequencer.sv
// Times presses and gaps of a debounced Morse key and emits one-cycle
// registered symbol strobes for the Morse detector.
//   clk            : system clock
//   rst            : asynchronous active-low reset
//   en             : sequencer enable (low forces IDLE, clears timer)
//   key_in         : raw asynchronous key, 1 = pressed
//   dot_inp        : dot strobe
//   dash_inp       : dash strobe
//   char_space_inp : end-of-character strobe
//   word_space_inp : end-of-word strobe
//   key_err        : stuck-key strobe
//   busy           : FSM not in IDLE
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES     = 8,
  parameter int unsigned DEB_CYCLES      = 2,
  parameter int unsigned MAX_PRESS_UNITS = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key_in,
  output logic dot_inp,
  output logic dash_inp,
  output logic char_space_inp,
  output logic word_space_inp,
  output logic key_err,
  output logic busy
);

  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_DASH  = CNT_W'(DASH_SPLIT_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_CHAR  = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_WORD  = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_STUCK = CNT_W'(MAX_PRESS_UNITS * UNIT_CYCLES);

  logic             key_db;
  logic             key_prev_q, key_prev_d;
  logic             key_rise;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             dot_q, dot_d, dash_q, dash_d;
  logic             char_q, char_d, word_q, word_d;
  logic             err_q, err_d, busy_q, busy_d;

  morse_key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .key_in(key_in),
    .key_db(key_db)
  );

  assign key_rise  = key_db & ~key_prev_q;
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    key_prev_d = key_db;
    state_d    = state_q;
    timer_d    = timer_q;
    dot_d      = 1'b0;
    dash_d     = 1'b0;
    char_d     = 1'b0;
    word_d     = 1'b0;
    err_d      = 1'b0;

    if (!en) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // edge-qualified so a key held across en low does not start a press
          if (key_rise) begin
            state_d = PRESS;
            timer_d = T_ONE;
          end
        end
        PRESS: begin
          if (!key_db) begin
            if (timer_q < T_DASH) dot_d  = 1'b1;
            else                  dash_d = 1'b1;
            state_d = GAP;
            timer_d = T_ONE;
          end else begin
            timer_d = timer_inc;
            if (timer_inc == T_STUCK) begin
              err_d   = 1'b1;
              state_d = STUCK;
            end
          end
        end
        STUCK: begin
          if (!key_db) begin
            state_d = GAP;
            timer_d = T_ONE;
          end else begin
            timer_d = timer_inc;
          end
        end
        GAP: begin
          // threshold strobe is independent of the key so a coincident
          // press still gets its space; the press then wins the next state
          timer_d = timer_inc;
          if (timer_inc == T_CHAR) begin
            char_d  = 1'b1;
            state_d = CHAR_DONE;
          end
          if (key_db) begin
            state_d = PRESS;
            timer_d = T_ONE;
          end
        end
        CHAR_DONE: begin
          timer_d = timer_inc;
          if (timer_inc == T_WORD) begin
            word_d  = 1'b1;
            state_d = IDLE;
            timer_d = '0;
          end
          if (key_db) begin
            state_d = PRESS;
            timer_d = T_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev_q <= 1'b0;
      state_q    <= IDLE;
      timer_q    <= '0;
      dot_q      <= 1'b0;
      dash_q     <= 1'b0;
      char_q     <= 1'b0;
      word_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      key_prev_q <= key_prev_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      dot_q      <= dot_d;
      dash_q     <= dash_d;
      char_q     <= char_d;
      word_q     <= word_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign dot_inp        = dot_q;
  assign dash_inp       = dash_q;
  assign char_space_inp = char_q;
  assign word_space_inp = word_q;
  assign key_err        = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Self-checking bench for morse_key_sequencer (UNIT_CYCLES=4, DEB_CYCLES=2,
// MAX_PRESS_UNITS=8). Key activity is described as alternating press/gap
// durations; a reference schedule of expected strobes and busy is computed
// from those durations and compared every cycle.
module tb_morse_key_sequencer;

  localparam int U    = 4;
  localparam int DEB  = 2;
  localparam int MAXP = 8;
  localparam int LAT  = 2 + DEB;   // key_in -> debounced key latency

  // observation vector {busy, key_err, word, char, dash, dot}
  localparam logic [5:0] DOT = 6'b000001;
  localparam logic [5:0] DSH = 6'b000010;
  localparam logic [5:0] CHR = 6'b000100;
  localparam logic [5:0] WRD = 6'b001000;
  localparam logic [5:0] ERR = 6'b010000;
  localparam logic [5:0] BSY = 6'b100000;

  logic clk = 1'b0;
  logic rst, en, key_in;
  logic dot_inp, dash_inp, char_space_inp, word_space_inp, key_err, busy;

  always #5 clk = ~clk;

  morse_key_sequencer #(
    .UNIT_CYCLES    (U),
    .DEB_CYCLES     (DEB),
    .MAX_PRESS_UNITS(MAXP),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .key_in        (key_in),
    .dot_inp       (dot_inp),
    .dash_inp      (dash_inp),
    .char_space_inp(char_space_inp),
    .word_space_inp(word_space_inp),
    .key_err       (key_err),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_a [0:4095];
  logic       lvl_a [0:4095];
  int         seg_q [$];

  int press_b [6] = '{2, 7, 8, 31, 32, 33};
  int gap_b   [6] = '{6, 7, 8, 18, 19, 20};

  task automatic check(input string tag, input logic [5:0] expv, input int cyc);
    logic [5:0] o;
    logic [4:0] s;
    o = {busy, key_err, word_space_inp, char_space_inp, dash_inp, dot_inp};
    s = o[4:0];
    checks++;
    assert (o === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, o, expv);
    end
    checks++;
    assert ($onehot0(s)) else begin
      errors++;
      $error("FAIL onehot cyc=%0d got=%b exp=at_most_one_strobe", cyc, s);
    end
  endtask

  // Expected schedule, cycle 0 = first cycle key_in is pressed.
  // Press of n clocks starting at s is seen debounced from s+LAT.
  //  - n >= MAXP*U   : key_err MAXP*U clocks into the debounced press
  //  - otherwise     : dot/dash one clock after the debounced release
  //  - gap timer starts at 1 on that clock, so a gap of g clocks reaches
  //    threshold T iff g >= T-1 (g == T-1 is the coincident-press case)
  //  - busy from one clock after the debounced press until the word strobe
  task automatic build_model(output int total);
    int s, n, g, stop;
    for (int i = 0; i < 4096; i++) begin
      exp_a[i] = '0;
      lvl_a[i] = 1'b0;
    end
    s = 0;
    for (int i = 0; i + 1 < seg_q.size(); i += 2) begin
      n = seg_q[i];
      g = seg_q[i+1];
      for (int c = s; c < s + n; c++) lvl_a[c] = 1'b1;
      if (n >= MAXP * U) exp_a[s + LAT + MAXP*U] |= ERR;
      else               exp_a[s + n + LAT + 1] |= (n < 2*U) ? DOT : DSH;
      if (g >= 2*U - 1) exp_a[s + n + LAT + 2*U] |= CHR;
      if (g >= 5*U - 1) begin
        exp_a[s + n + LAT + 5*U] |= WRD;
        stop = s + n + LAT + 5*U;
      end else begin
        stop = s + n + g + LAT + 1;
      end
      for (int c = s + LAT + 1; c < stop; c++) exp_a[c] |= BSY;
      s += n + g;
    end
    total = s;
  endtask

  // Entered and left #1 after a rising edge. en_off >= 0 drops en after
  // that cycle's edge; outputs must be 0 from the next cycle on.
  task automatic run_sequence(input string tag, input int en_off);
    int total;
    logic [5:0] expv;
    build_model(total);
    for (int c = 0; c < total; c++) begin
      key_in = lvl_a[c];
      if (c == en_off) en = 1'b0;
      @(negedge clk);
      expv = (en_off >= 0 && c > en_off) ? 6'b0 : exp_a[c];
      check(tag, expv, c);
      @(posedge clk);
      #1;
    end
    key_in = 1'b0;
    en     = 1'b1;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check(tag, 6'b0, c);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    key_in = 1'b0;
    #1 rst = 1'b0;
    #2 check("reset", 6'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle_check("post_reset", 5);

    // single dot with char and word space
    seg_q = '{4, 30};
    run_sequence("dot_word", -1);

    // dash, short gap, dot
    seg_q = '{12, 5, 3, 30};
    run_sequence("dash_dot", -1);

    // dot/dash split boundary
    seg_q = '{7, 10, 8, 30};
    run_sequence("split", -1);

    // 1-clock glitch while idle
    for (int c = 0; c < 20; c++) begin
      key_in = (c == 0);
      @(negedge clk);
      check("glitch", 6'b0, c);
      @(posedge clk);
      #1;
    end
    key_in = 1'b0;

    // stuck key
    seg_q = '{40, 30};
    run_sequence("stuck", -1);

    // coincident press exactly at char / word thresholds
    seg_q = '{4, 2*U - 1, 4, 5*U - 1, 12, 30};
    run_sequence("coincide", -1);

    // reset mid-press
    for (int c = 0; c < 10; c++) begin
      key_in = 1'b1;
      @(negedge clk);
      if (c == 8) check("rst_busy", BSY, c);
      @(posedge clk);
      #1;
    end
    #3 rst = 1'b0;
    #1 check("rst_mid", 6'b0, 0);
    key_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle_check("rst_recover", 10);
    seg_q = '{4, 30};
    run_sequence("rst_dot", -1);

    // en low mid-gap, then recovery
    seg_q = '{4, 30};
    run_sequence("en_gap", 12);
    idle_check("en_recover", 5);
    seg_q = '{4, 30};
    run_sequence("en_dot", -1);

    // randomized press/gap trains
    for (int t = 0; t < 12; t++) begin
      seg_q = {};
      for (int k = 0; k < 3; k++) begin
        seg_q.push_back($urandom_range(0, 1) ? press_b[$urandom_range(0, 5)]
                                             : int'($urandom_range(2, 36)));
        if (k == 2) seg_q.push_back(30);
        else seg_q.push_back($urandom_range(0, 1) ? gap_b[$urandom_range(0, 5)]
                                                  : int'($urandom_range(2, 26)));
      end
      run_sequence("random", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
